// File: rtl/axis_burst_framer.sv
// Purpose: frame tlast-delimited wide peak bursts into header + per-channel word packets for the host DMA stream.
// Latency: header is valid 1 cycle after the first beat is seen in IDLE; each input beat then costs 1 LOAD cycle plus NUM_CHANNELS words.
// Backpressure: m_axis_tready low stalls every state losslessly; s_axis_tready is raised only while the hold register is empty (LOAD).
module axis_burst_framer #(
    parameter int          NUM_CHANNELS  = 4,
    parameter int          CHANNEL_WIDTH = 64,
    parameter int          BURST_LENGTH  = 32,
    parameter logic [15:0] MAGIC         = 16'hA5C3
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
    input  logic                                  s_axis_tlast,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [CHANNEL_WIDTH-1:0]              m_axis_tdata,
    output logic                                  m_axis_tlast,
    output logic                                  err_overlen
);

    // The header word is {MAGIC[15:0], seq[15:0], timestamp[31:0]}, so CHANNEL_WIDTH must be 64.
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W = $clog2(BURST_LENGTH + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // beat_cnt value while the beat being accepted is the last one a packet may hold
    localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_LOAD = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t                                state_q, state_d;
    logic [31:0]                           ts_q;
    logic [15:0]                           seq_q, seq_d;
    logic [CNT_W-1:0]                      beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]                      word_idx_q, word_idx_d;
    logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] hold_q, hold_d;
    logic                                  last_f_q, last_f_d;
    logic                                  force_f_q, force_f_d;
    logic [CHANNEL_WIDTH-1:0]              m_tdata_q, m_tdata_d;
    logic                                  m_tvalid_q, m_tvalid_d;
    logic                                  m_tlast_q, m_tlast_d;
    logic                                  err_d;

    logic                                  m_hs;
    logic                                  at_final;
    logic [IDX_W-1:0]                      nxt_idx;

    assign m_hs     = m_tvalid_q & m_axis_tready;
    assign at_final = (beat_cnt_q == FINAL_CNT);
    assign nxt_idx  = word_idx_q + IDX_ONE;

    // Next-state, datapath loads and the registered output word for the coming cycle.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        beat_cnt_d = beat_cnt_q;
        word_idx_d = word_idx_q;
        hold_d     = hold_q;
        last_f_d   = last_f_q;
        force_f_d  = force_f_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Peek at the first beat only to stamp the header; the beat itself is taken in LOAD.
                if (s_axis_tvalid) begin
                    m_tdata_d  = {MAGIC, seq_q, ts_q};
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b0;
                    state_d    = S_HDR;
                end
            end

            S_HDR: begin
                if (m_hs) begin
                    m_tvalid_d = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                if (s_axis_tvalid) begin
                    hold_d     = s_axis_tdata;
                    last_f_d   = s_axis_tlast | at_final;
                    force_f_d  = at_final & ~s_axis_tlast;
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                    word_idx_d = '0;
                    // Channel 0 goes straight to the output register so SEND starts with a valid word.
                    m_tdata_d  = s_axis_tdata[0 +: CHANNEL_WIDTH];
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = (s_axis_tlast | at_final) & (LAST_IDX == '0);
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                if (m_hs) begin
                    if (word_idx_q != LAST_IDX) begin
                        word_idx_d = nxt_idx;
                        m_tdata_d  = hold_q[32'(nxt_idx) * CHANNEL_WIDTH +: CHANNEL_WIDTH];
                        m_tlast_d  = last_f_q & (nxt_idx == LAST_IDX);
                    end else begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        if (last_f_q) begin
                            seq_d   = seq_q + 16'd1;
                            err_d   = force_f_q;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                m_tvalid_d = 1'b0;
                m_tlast_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; the timestamp free-runs independently of the FSM and of stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            seq_q      <= '0;
            beat_cnt_q <= '0;
            word_idx_q <= '0;
            hold_q     <= '0;
            last_f_q   <= 1'b0;
            force_f_q  <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + 32'd1;
            seq_q      <= seq_d;
            beat_cnt_q <= beat_cnt_d;
            word_idx_q <= word_idx_d;
            hold_q     <= hold_d;
            last_f_q   <= last_f_d;
            force_f_q  <= force_f_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    // Gated by rstn so neither strobe can fire while a reset is being applied.
    assign s_axis_tready = rstn & (state_q == S_LOAD);
    assign err_overlen   = rstn & err_d;

endmodule

// File: tb/tb_axis_burst_framer.sv
module tb_axis_burst_framer;
    localparam int NC  = 4;
    localparam int CW  = 64;
    localparam int BL  = 32;
    localparam logic [15:0] MAGIC = 16'hA5C3;

    typedef struct { logic [NC*CW-1:0] data; logic last; } beat_t;
    typedef struct { logic [63:0] data; logic last; logic err; logic hdr; } word_t;
    typedef struct { int len; bit rnd; int pkts; int words; int errs; } row_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [NC*CW-1:0] s_tdata = '0;
    logic            s_tlast = 1'b0;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic [CW-1:0]   m_tdata;
    logic            m_tlast;
    logic            err;

    axis_burst_framer #(
        .NUM_CHANNELS (NC),
        .CHANNEL_WIDTH(CW),
        .BURST_LENGTH (BL),
        .MAGIC        (MAGIC)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata (s_tdata),
        .s_axis_tlast (s_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tlast (m_tlast),
        .err_overlen  (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pkts_seen = 0;
    int words_seen = 0;
    int errs_seen = 0;
    bit rnd_rdy = 1'b0;
    bit abort = 1'b0;
    bit idle_exp = 1'b1;
    bit prev_stall = 1'b0;
    logic [63:0] prev_dat = '0;
    logic prev_last = 1'b0;
    logic [15:0] seq_model = '0;
    logic [31:0] tb_ts = '0;

    beat_t beat_q[$];
    word_t exp_q[$];
    logic [31:0] ts_exp[$];
    row_t rows[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference cycle counter: zero under reset, +1 on every clock otherwise.
    always @(posedge clk) begin
        if (!rstn) tb_ts <= '0;
        else       tb_ts <= tb_ts + 32'd1;
    end

    // Output ready: always 1 or a fair coin, changed just after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference model: a burst of len beats becomes ceil(len/BL) packets; every
    // packet is a header then its beats split into NC words, the last word tagged
    // tlast, and tagged err when the packet was cut at BL with beats still to come.
    task automatic add_burst(input int len);
        beat_t arr[$];
        beat_t b;
        word_t w;
        int rem, pos, chunk;
        bit forced;
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < NC*CW/32; k++) b.data[k*32 +: 32] = $urandom;
            b.last = (i == len - 1);
            arr.push_back(b);
            beat_q.push_back(b);
        end
        rem = len;
        pos = 0;
        while (rem > 0) begin
            chunk  = (rem > BL) ? BL : rem;
            forced = (rem > BL);
            w.hdr = 1'b1; w.data = {MAGIC, seq_model, 32'h0}; w.last = 1'b0; w.err = 1'b0;
            exp_q.push_back(w);
            for (int j = 0; j < chunk; j++) begin
                for (int c = 0; c < NC; c++) begin
                    w.hdr  = 1'b0;
                    w.data = arr[pos + j].data[c*CW +: CW];
                    w.last = (j == chunk - 1) && (c == NC - 1);
                    w.err  = w.last && forced;
                    exp_q.push_back(w);
                end
            end
            pos += chunk;
            rem -= chunk;
            seq_model = seq_model + 16'd1;
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. what the next rising edge will transfer.
    always @(negedge clk) begin : mon
        word_t e;
        logic exp_err;
        logic [63:0] expd;
        logic [31:0] tse;
        if (!rstn) begin
            idle_exp   = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(m_tvalid), 64'd1);
                chk("stall_data", m_tdata, prev_dat);
                chk("stall_last", 64'(m_tlast), 64'(prev_last));
            end
            if (idle_exp && s_tvalid) begin
                ts_exp.push_back(tb_ts);
                idle_exp = 1'b0;
            end
            exp_err = 1'b0;
            if (m_tvalid && m_tready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_word: got %h expected no word", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    expd = e.data;
                    if (e.hdr) begin
                        if (ts_exp.size() > 0) tse = ts_exp.pop_front();
                        else begin
                            n_cmp++; n_bad++;
                            $display("FAIL hdr_ts: got header %h expected a preceding burst start", m_tdata);
                            tse = '0;
                        end
                        expd[31:0] = tse;
                    end
                    chk(e.hdr ? "hdr_word" : "data_word", m_tdata, expd);
                    chk("word_last", 64'(m_tlast), 64'(e.last));
                    exp_err = e.err;
                end
                if (m_tlast) begin
                    pkts_seen++;
                    idle_exp = 1'b1;
                end
            end
            chk("err_overlen", 64'(err), 64'(exp_err));
            if (err) errs_seen++;
            prev_stall = m_tvalid && !m_tready;
            prev_dat   = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic drive_beats();
        beat_t b;
        bit hs;
        int cyc;
        while (beat_q.size() > 0 && !abort) begin
            b = beat_q.pop_front();
            s_tvalid = 1'b1;
            s_tdata  = b.data;
            s_tlast  = b.last;
            hs  = 1'b0;
            cyc = 0;
            while (!hs && !abort) begin
                @(negedge clk);
                hs = s_tready;
                @(posedge clk);
                #1;
                cyc++;
                if (cyc > 3000) begin
                    n_cmp++; n_bad++;
                    $display("FAIL drive_timeout: got no s_axis_tready in %0d cycles expected acceptance", cyc);
                    beat_q.delete();
                    hs = 1'b1;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || ts_exp.size() != 0) && c < 6000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 6000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d words outstanding expected 0", exp_q.size());
            exp_q.delete();
            ts_exp.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        exp_q.delete();
        ts_exp.delete();
        beat_q.delete();
        seq_model = '0;
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        //           len rnd pkts words errs
        rows[0] = '{  2, 0,  1,    9,   0};
        rows[1] = '{ 40, 0,  2,  162,   1};
        rows[2] = '{  1, 1,  1,    5,   0};
        rows[3] = '{  5, 1,  1,   21,   0};
        rows[4] = '{ 32, 1,  1,  129,   0};
        rows[5] = '{ 33, 0,  2,  134,   1};
        rows[6] = '{ 64, 1,  2,  258,   1};

        do_reset();

        // Header stamp: first beat visible while the counter reads 0x100.
        c = 0;
        while (tb_ts != 32'h100 && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        add_burst(1);
        fork
            drive_beats();
            begin
                @(negedge clk);
                @(negedge clk);
                chk("ts_hdr_valid", 64'(m_tvalid), 64'd1);
                chk("ts_hdr_lo", 64'(m_tdata[31:0]), 64'h100);
                chk("ts_hdr_hi", 64'(m_tdata[63:32]), {32'h0, MAGIC, 16'h0000});
            end
        join
        wait_drain();

        do_reset();
        for (int r = 0; r < 7; r++) begin
            pkts_seen = 0; words_seen = 0; errs_seen = 0;
            rnd_rdy = rows[r].rnd;
            add_burst(rows[r].len);
            drive_beats();
            wait_drain();
            chk($sformatf("row%0d_pkts", r), 64'(pkts_seen), 64'(rows[r].pkts));
            chk($sformatf("row%0d_words", r), 64'(words_seen), 64'(rows[r].words));
            chk($sformatf("row%0d_errs", r), 64'(errs_seen), 64'(rows[r].errs));
            rnd_rdy = 1'b0;
        end

        // Random back-to-back bursts under random backpressure.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 6; k++) add_burst($urandom_range(1, 70));
        drive_beats();
        wait_drain();
        rnd_rdy = 1'b0;

        // Sequence wrap: park seq at 0xFFFF, then two single-beat bursts.
        force dut.seq_q = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        release dut.seq_q;
        seq_model = 16'hFFFF;
        pkts_seen = 0;
        add_burst(1);
        add_burst(1);
        drive_beats();
        wait_drain();
        chk("wrap_pkts", 64'(pkts_seen), 64'd2);

        // Reset while beat 3 of a 5-beat burst is being serialized.
        words_seen = 0;
        add_burst(5);
        fork
            drive_beats();
            begin
                c = 0;
                while (words_seen < 10 && c < 2000) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
                rstn  = 1'b0;
                abort = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
                chk("midrst_s_tready", 64'(s_tready), 64'd0);
            end
        join
        exp_q.delete();
        ts_exp.delete();
        beat_q.delete();
        seq_model = '0;
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        abort = 1'b0;
        pkts_seen = 0; words_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        add_burst(1);
        drive_beats();
        wait_drain();
        chk("postrst_pkts", 64'(pkts_seen), 64'd1);
        chk("postrst_words", 64'(words_seen), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
